sequence_pattern_generator: RTL and testbench
=============================================

Name: sequence_pattern_generator

Overview:
Serial transmitter producing the 6-bit framing pattern 110101, MSB first, one bit per clock, for the downstream sequence pattern detector. On a start request it emits the pattern a programmable number of times, with an optional programmable idle gap between repetitions, then pulses done. It sits upstream of the detector and drives its `in` input directly. It also serves as the detector's bench stimulus source.

Parameters:
PAT_LEN, 6, pattern length in bits (range 2..16)
PATTERN, 6'b110101, pattern bits, transmitted MSB (bit PAT_LEN-1) first
CNT_W, 8, width of repetition counter

Ports:
clk  input  1  rising-edge clock
restn  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
repeat_cnt  input  CNT_W  number of pattern repetitions; latched on accepted start
gap_len  input  4  idle bits between repetitions; latched on accepted start
abort  input  1  synchronous abort; stops transmission without done
out  output  1  serial data bit (registered)
valid  output  1  high while out carries a pattern bit (registered)
busy  output  1  high from first bit through last bit/gap (registered)
done  output  1  one-cycle pulse after final bit of final repetition

Behaviour:
- Reset: clk and restn are the only clock and reset. Reset is asynchronous and active-low. On restn=0, all outputs are 0 immediately; state=IDLE; counters=0. Deassertion is taken at the next clk edge.
- FSM states, encoded in binary: IDLE, SEND, GAP, DONE.
- IDLE: out=0, valid=0, busy=0.
  - start=1 with repeat_cnt!=0 → accepted. Latch repeat_cnt and gap_len, load bit index PAT_LEN-1, go to SEND.
  - start=1 with repeat_cnt=0 → ignored. Stay in IDLE, no done.
- Latency: accepted start sampled at edge t; first pattern bit (PATTERN[PAT_LEN-1]) appears on out with valid=1, busy=1 after edge t+1.
- SEND: each cycle out=PATTERN[idx], valid=1, busy=1, and idx decrements. After idx=0:
  - remaining reps > 1 and gap_len != 0 → GAP.
  - remaining reps > 1 and gap_len = 0 → reload idx and stay in SEND (back-to-back, no bubble).
  - last rep → DONE.
- GAP: gap_len cycles of out=0, valid=0, busy=1. Then reload idx and return to SEND. No gap is inserted after the final repetition.
- DONE: a single cycle with done=1, busy=0, valid=0, out=0. Then IDLE unconditionally. start during DONE is ignored.
- start while busy (SEND/GAP): ignored. Latched values are unchanged.
- abort=1 in SEND/GAP: next cycle state=IDLE, all outputs 0, no done pulse.
- abort in IDLE/DONE: no effect. abort has priority over start in the same cycle.
- Repetition counter: CNT_W bits, decrements at the end of each repetition. repeat_cnt = 2^CNT_W-1 is legal; no wrap-around occurs.
- out and valid are glitch-free register outputs; out=0 whenever valid=0.
- Total cycles from accepted start to done for N reps, gap G: N*PAT_LEN + (N-1)*G, then done.

Decomposition:
- Shared package `seq_pattern_pkg`:
  - state encoding constants (IDLE/SEND/GAP/DONE)
  - default PATTERN/PAT_LEN constants, shared with the detector so both ends agree on the pattern
- One natural sub-module: `pattern_shift_reg`. Parallel-loads PATTERN and shifts out MSB first, with a load/shift interface and a last-bit flag. The FSM and counters stay in the top module.

Test Plan:
- repeat_cnt=1, gap_len=0, start pulse at cycle 0 → out=1,1,0,1,0,1 with valid=1 on cycles 1–6. done=1 on cycle 7 only; busy=1 on cycles 1–6. Chained detector out=1 once.
- repeat_cnt=2, gap_len=0 → out=110101110101 contiguous over cycles 1–12, done on cycle 13. Chained detector fires twice.
- repeat_cnt=2, gap_len=2 → out=110101,0,0,110101 with valid low only on the two gap cycles, busy high throughout, done on cycle 15.
- repeat_cnt=0 with start=1 → busy, valid and done stay 0; a following start with repeat_cnt=1 works normally.
- repeat_cnt=3; at cycle 4 assert start (ignored); at cycle 8 assert abort → outputs 0 from cycle 9 and no done; a new start is accepted on cycle 10.
- repeat_cnt=1, drop restn mid-SEND, asynchronously between clock edges → out, valid and busy go to 0 before the next edge. After release and a new start, the full pattern is sent from bit 5.

Source files
------------

// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the framing-pattern generator and its downstream
// detector: pattern constants, controller state encoding and output bundle.
package seq_pattern_pkg;

  // Framing pattern shared by both ends of the link, transmitted MSB first.
  localparam int unsigned SEQ_PAT_LEN = 6;
  localparam logic [SEQ_PAT_LEN-1:0] SEQ_PATTERN = 6'b110101;

  // Default width of the repetition counter.
  localparam int unsigned SEQ_CNT_W = 8;

  // Width of the programmable idle gap between repetitions.
  localparam int unsigned SEQ_GAP_W = 4;

  // Controller state encoding (binary).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Registered output bundle presented to the detector / bench.
  typedef struct packed {
    logic out;
    logic valid;
    logic busy;
    logic done;
  } seq_out_t;

  // True while the controller is in the middle of a transmission.
  function automatic logic seq_is_active(input logic [1:0] state);
    return (state == ST_SEND) || (state == ST_GAP);
  endfunction

endpackage

// File: rtl/pattern_shift_reg.sv
// Parallel-load shift register that serialises the framing pattern MSB first.
// o_last flags that the bit currently on o_bit is the final bit of the pattern.
module pattern_shift_reg
  import seq_pattern_pkg::*;
#(
  parameter int unsigned PAT_LEN = SEQ_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(SEQ_PATTERN)
) (
  input  logic clk,
  input  logic restn,
  input  logic i_load,
  input  logic i_shift,
  output logic o_bit,
  output logic o_last
);

  localparam int unsigned IDX_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] r_data;
  logic [IDX_W-1:0]   r_idx;

  // Load the pattern (load wins over shift so a repetition can restart on its last bit).
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      r_data <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_data <= PATTERN;
      r_idx  <= IDX_TOP;
    end else if (i_shift) begin
      r_data <= {r_data[PAT_LEN-2:0], 1'b0};
      if (r_idx != '0) begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign o_bit  = r_data[PAT_LEN-1];
  assign o_last = (r_idx == '0);

endmodule

// File: rtl/sequence_pattern_generator.sv
// Serial framing-pattern transmitter. On an accepted start it sends PATTERN
// repeat_cnt times, with gap_len idle bits between repetitions, then pulses done.
//
// state | meaning
// IDLE  | waiting for start with a non-zero repetition count
// SEND  | shifting pattern bits out, one per clock
// GAP   | idle bits between two repetitions (busy stays high)
// DONE  | single cycle that raises done, then back to IDLE
//
// All outputs are registered from the current state, so they trail the state
// register by one clock: a start taken at edge t shows its first bit after t+1.
module sequence_pattern_generator
  import seq_pattern_pkg::*;
#(
  parameter int unsigned PAT_LEN = SEQ_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(SEQ_PATTERN),
  parameter int unsigned CNT_W = SEQ_CNT_W
) (
  input  logic                 clk,
  input  logic                 restn,
  input  logic                 start,
  input  logic [CNT_W-1:0]     repeat_cnt,
  input  logic [SEQ_GAP_W-1:0] gap_len,
  input  logic                 abort,
  output logic                 out,
  output logic                 valid,
  output logic                 busy,
  output logic                 done
);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_reps;
  logic [SEQ_GAP_W-1:0] r_gap_len;
  logic [SEQ_GAP_W-1:0] r_gap_cnt;
  seq_out_t             r_outs;

  logic [1:0]           w_state_nxt;
  logic [CNT_W-1:0]     w_reps_nxt;
  logic [SEQ_GAP_W-1:0] w_gap_len_nxt;
  logic [SEQ_GAP_W-1:0] w_gap_cnt_nxt;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_bit;
  logic                 w_last;

  pattern_shift_reg #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_shift (
    .clk     (clk),
    .restn   (restn),
    .i_load  (w_load),
    .i_shift (w_shift),
    .o_bit   (w_bit),
    .o_last  (w_last)
  );

  // Next-state, counter and shift-register control decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_reps_nxt    = r_reps;
    w_gap_len_nxt = r_gap_len;
    w_gap_cnt_nxt = r_gap_cnt;
    w_load        = 1'b0;
    w_shift       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A zero repetition count is a no-op request and is dropped here.
        if (start && (repeat_cnt != '0)) begin
          w_reps_nxt    = repeat_cnt;
          w_gap_len_nxt = gap_len;
          w_gap_cnt_nxt = '0;
          w_load        = 1'b1;
          w_state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort) begin
          w_reps_nxt    = '0;
          w_gap_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_shift = 1'b1;
          if (w_last) begin
            w_reps_nxt = r_reps - 1'b1;
            if (r_reps > CNT_W'(1)) begin
              if (r_gap_len != '0) begin
                // Down-counter terminates at zero, so preload gap_len-1.
                w_gap_cnt_nxt = r_gap_len - 1'b1;
                w_state_nxt   = ST_GAP;
              end else begin
                w_load = 1'b1;
              end
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
      end
      ST_GAP: begin
        if (abort) begin
          w_reps_nxt    = '0;
          w_gap_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end else if (r_gap_cnt == '0) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      r_state   <= ST_IDLE;
      r_reps    <= '0;
      r_gap_len <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_reps    <= w_reps_nxt;
      r_gap_len <= w_gap_len_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  // Glitch-free registered outputs decoded from the current state; out is gated by SEND.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      r_outs <= '0;
    end else begin
      r_outs.out   <= (r_state == ST_SEND) & w_bit;
      r_outs.valid <= (r_state == ST_SEND);
      r_outs.busy  <= seq_is_active(r_state);
      r_outs.done  <= (r_state == ST_DONE);
    end
  end

  assign out   = r_outs.out;
  assign valid = r_outs.valid;
  assign busy  = r_outs.busy;
  assign done  = r_outs.done;

endmodule

// File: tb/tb_sequence_pattern_generator.sv
// Scoreboard bench for sequence_pattern_generator: the stimulus side computes the
// expected cycle-by-cycle output stream from the framing rules and queues it with
// its expected cycle number; a monitor pops and compares whenever the DUT is active.
module tb_sequence_pattern_generator;

  localparam logic [5:0] PAT = 6'b110101;

  typedef struct {
    logic o;
    logic v;
    logic b;
    logic d;
    int   t;
  } exp_t;

  logic       clk = 1'b0;
  logic       restn;
  logic       start;
  logic [7:0] repeat_cnt;
  logic [3:0] gap_len;
  logic       abort;
  logic       out;
  logic       valid;
  logic       busy;
  logic       done;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  sequence_pattern_generator dut (
    .clk        (clk),
    .restn      (restn),
    .start      (start),
    .repeat_cnt (repeat_cnt),
    .gap_len    (gap_len),
    .abort      (abort),
    .out        (out),
    .valid      (valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every active output cycle must match the head of the expected stream.
  always @(negedge clk) begin
    exp_t e;
    if (restn === 1'b1 && ((out | valid | busy | done) === 1'b1)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d got out=%b valid=%b busy=%b done=%b required all 0",
                 cyc, out, valid, busy, done);
      end else begin
        e = exp_q.pop_front();
        if (out !== e.o || valid !== e.v || busy !== e.b || done !== e.d || cyc != e.t) begin
          errors++;
          $display("FAIL stream cyc=%0d got out=%b valid=%b busy=%b done=%b required out=%b valid=%b busy=%b done=%b at cyc=%0d",
                   cyc, out, valid, busy, done, e.o, e.v, e.b, e.d, e.t);
        end
      end
    end
  end

  // Reference stream: N copies of the pattern MSB first, G idle busy cycles between copies, then done.
  task automatic build_stream(input int n, input int g, output exp_t lst[$]);
    logic [5:0] pv;
    exp_t e;
    pv = PAT;
    lst.delete();
    for (int r = 0; r < n; r++) begin
      for (int b = 5; b >= 0; b--) begin
        e.o = pv[b]; e.v = 1'b1; e.b = 1'b1; e.d = 1'b0; e.t = 0;
        lst.push_back(e);
      end
      if (r < n - 1) begin
        for (int k = 0; k < g; k++) begin
          e.o = 1'b0; e.v = 1'b0; e.b = 1'b1; e.d = 1'b0; e.t = 0;
          lst.push_back(e);
        end
      end
    end
    e.o = 1'b0; e.v = 1'b0; e.b = 1'b0; e.d = 1'b1; e.t = 0;
    lst.push_back(e);
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s pending=%0d required 0 (cyc=%0d)", name, exp_q.size(), cyc);
      exp_q.delete();
    end
  endtask

  // One transaction. abort_at>0 aborts at that output cycle; stray adds ignored start requests.
  // Called and returns 1 time unit after a rising edge.
  task automatic run_txn(input int n, input int g, input int abort_at, input bit stray);
    exp_t lst[$];
    exp_t e;
    int   t0;
    int   len;
    int   kmax;
    build_stream(n, g, lst);
    len  = lst.size();
    kmax = (abort_at > 0) ? abort_at : len;
    start      = 1'b1;
    repeat_cnt = 8'(n);
    gap_len    = 4'(g);
    abort      = 1'b0;
    t0 = cyc + 1;
    for (int k = 1; k <= kmax; k++) begin
      e = lst[k-1];
      e.t = t0 + k;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    start      = 1'b0;
    repeat_cnt = 8'($urandom);
    gap_len    = 4'($urandom);
    for (int k = 1; k <= kmax; k++) begin
      abort = (k == abort_at);
      if (abort_at == 0 && k == len) abort = 1'($urandom_range(0, 1));
      start = stray && ($urandom_range(0, 3) == 0);
      if (start) begin
        repeat_cnt = 8'($urandom_range(1, 255));
        gap_len    = 4'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_drained("txn_drain");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int g;
    int len;
    restn = 1'b1; start = 1'b0; abort = 1'b0; repeat_cnt = '0; gap_len = '0;
    #2 restn = 1'b0;
    #1;
    checks++;
    if ({out, valid, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_state got %b required 0000", {out, valid, busy, done});
    end
    repeat (3) @(negedge clk);
    restn = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the framing rules.
    run_txn(1, 0, 0, 1'b0);
    run_txn(2, 0, 0, 1'b0);
    run_txn(2, 2, 0, 1'b0);

    // Zero repetition count is ignored, then a normal start works.
    start = 1'b1; repeat_cnt = 8'd0; gap_len = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({valid, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL zero_reps got valid/busy/done=%b required 000", {valid, busy, done});
    end
    run_txn(1, 0, 0, 1'b0);

    // Ignored start mid-run, abort at output cycle 8, then immediate restart.
    run_txn(3, 0, 8, 1'b1);
    run_txn(1, 3, 0, 1'b0);

    // Asynchronous reset in the middle of a transmission.
    begin
      exp_t lst[$];
      exp_t e;
      int   t0;
      build_stream(1, 0, lst);
      start = 1'b1; repeat_cnt = 8'd1; gap_len = 4'd0;
      t0 = cyc + 1;
      for (int k = 1; k <= 3; k++) begin
        e = lst[k-1];
        e.t = t0 + k;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({valid, busy} !== 2'b11) begin
        errors++;
        $display("FAIL pre_reset_active got valid/busy=%b required 11", {valid, busy});
      end
      #2 restn = 1'b0;
      #1;
      checks++;
      if ({out, valid, busy, done} !== 4'b0000) begin
        errors++;
        $display("FAIL async_reset got %b required 0000", {out, valid, busy, done});
      end
      exp_q.delete();
      @(negedge clk);
      restn = 1'b1;
      @(posedge clk); #1;
      run_txn(1, 0, 0, 1'b0);
    end

    // Full-scale repetition count.
    run_txn(255, 0, 0, 1'b0);

    // Randomised transactions.
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(1, 5);
      g = $urandom_range(0, 15);
      len = n * 6 + (n - 1) * g + 1;
      if ($urandom_range(0, 3) == 0) begin
        run_txn(n, g, $urandom_range(1, len - 1), 1'b1);
      end else begin
        run_txn(n, g, 0, 1'($urandom_range(0, 1)));
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    check_drained("final_drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
